// File: rtl/hls_macc_vec.sv
// Signed LANES-element dot-product core with ap_ctrl_hs handshake.
// One product is accumulated per MAC cycle, with optional accumulate-onto-previous and saturation.
module hls_macc_vec #(
  parameter int unsigned W     = 16,
  parameter int unsigned LANES = 4,
  parameter int unsigned ACC_W = 40,
  parameter int unsigned SAT   = 0
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 ap_start,
  output logic                 ap_done,
  output logic                 ap_idle,
  output logic                 ap_ready,
  input  logic                 acc_clr,
  input  logic [LANES*W-1:0]   a_vec,
  input  logic [LANES*W-1:0]   b_vec,
  output logic [ACC_W-1:0]     out1,
  output logic                 out1_ap_vld,
  output logic                 ovf,
  output logic [ACC_W-1:0]     ap_return
);

  localparam int unsigned IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned VEC_W = LANES * W;
  localparam int unsigned P_W   = 2 * W;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LANES - 1);
  localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

  // One-hot encoding; bit positions double as output decodes.
  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_MAC  = 3'b010,
    S_DONE = 3'b100
  } state_e;

  localparam int unsigned ST_IDLE_BIT = 0;
  localparam int unsigned ST_DONE_BIT = 2;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic [VEC_W-1:0]   a_q,     a_d;
  logic [VEC_W-1:0]   b_q,     b_d;
  logic [ACC_W-1:0]   acc_q,   acc_d;
  logic               ovf_q,   ovf_d;

  logic [W-1:0]       a_sel_c;
  logic [W-1:0]       b_sel_c;
  logic [P_W-1:0]     a_ext_c;
  logic [P_W-1:0]     b_ext_c;
  logic [P_W-1:0]     prod_c;
  logic [ACC_W-1:0]   prod_ext_c;
  logic [ACC_W-1:0]   sum_c;
  logic               add_ovf_c;
  logic [ACC_W-1:0]   acc_add_c;

  // Lane select for the current index.
  always_comb begin
    a_sel_c = '0;
    b_sel_c = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_sel_c = a_q[i*W +: W];
        b_sel_c = b_q[i*W +: W];
      end
    end
  end

  // Sign-extended operands make the low P_W bits of the product the exact signed product.
  assign a_ext_c = {{W{a_sel_c[W-1]}}, a_sel_c};
  assign b_ext_c = {{W{b_sel_c[W-1]}}, b_sel_c};
  assign prod_c  = a_ext_c * b_ext_c;

  generate
    if (ACC_W > P_W) begin : g_prod_sext
      assign prod_ext_c = {{(ACC_W-P_W){prod_c[P_W-1]}}, prod_c};
    end else begin : g_prod_direct
      assign prod_ext_c = prod_c;
    end
  endgenerate

  // Signed overflow: operands agree in sign but the wrapped sum does not.
  assign sum_c     = acc_q + prod_ext_c;
  assign add_ovf_c = (acc_q[ACC_W-1] == prod_ext_c[ACC_W-1]) &&
                     (sum_c[ACC_W-1] != acc_q[ACC_W-1]);

  always_comb begin
    acc_add_c = sum_c;
    if ((SAT != 0) && add_ovf_c) begin
      acc_add_c = acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX;
    end
  end

  // State and datapath registers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (ap_start) begin
          a_d     = a_vec;
          b_d     = b_vec;
          if (acc_clr) begin
            acc_d = '0;
          end
          ovf_d   = 1'b0;
          idx_d   = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_add_c;
        if (add_ovf_c) begin
          ovf_d = 1'b1;
        end
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are register bits; only ap_idle looks at ap_start directly.
  assign ap_done     = state_q[ST_DONE_BIT];
  assign ap_ready    = state_q[ST_DONE_BIT];
  assign out1_ap_vld = state_q[ST_DONE_BIT];
  assign ap_idle     = state_q[ST_IDLE_BIT] & ~ap_start;
  assign out1        = acc_q;
  assign ap_return   = acc_q;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_hls_macc_vec.sv
// Directed bench for hls_macc_vec: default 40-bit wrap core plus 32-bit wrap and saturating cores
// driven from the same stimulus.
module tb_hls_macc_vec;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b1;
  logic        ap_start = 1'b0;
  logic        acc_clr = 1'b0;
  logic [63:0] a_vec = '0;
  logic [63:0] b_vec = '0;

  logic        d_done, d_idle, d_ready, d_vld, d_ovf;
  logic [39:0] d_out1, d_ret;
  logic        w_done, w_idle, w_ready, w_vld, w_ovf;
  logic [31:0] w_out1, w_ret;
  logic        s_done, s_idle, s_ready, s_vld, s_ovf;
  logic [31:0] s_out1, s_ret;

  int n_chk = 0;
  int n_err = 0;

  always #5 ap_clk = ~ap_clk;

  hls_macc_vec u_dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_done(d_done),
    .ap_idle(d_idle), .ap_ready(d_ready), .acc_clr(acc_clr), .a_vec(a_vec), .b_vec(b_vec),
    .out1(d_out1), .out1_ap_vld(d_vld), .ovf(d_ovf), .ap_return(d_ret)
  );

  hls_macc_vec #(.W(16), .LANES(4), .ACC_W(32), .SAT(0)) u_wrap (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_done(w_done),
    .ap_idle(w_idle), .ap_ready(w_ready), .acc_clr(acc_clr), .a_vec(a_vec), .b_vec(b_vec),
    .out1(w_out1), .out1_ap_vld(w_vld), .ovf(w_ovf), .ap_return(w_ret)
  );

  hls_macc_vec #(.W(16), .LANES(4), .ACC_W(32), .SAT(1)) u_sat (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_done(s_done),
    .ap_idle(s_idle), .ap_ready(s_ready), .acc_clr(acc_clr), .a_vec(a_vec), .b_vec(b_vec),
    .out1(s_out1), .out1_ap_vld(s_vld), .ovf(s_ovf), .ap_return(s_ret)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pack4(input int e0, input int e1, input int e2, input int e3);
    return {16'(e3), 16'(e2), 16'(e1), 16'(e0)};
  endfunction

  // One transaction on the default core; checks latency, DONE-cycle outputs and the pulse width.
  task automatic run_txn(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic clr, input logic [39:0] exp, input logic exp_ovf,
                         input bit disturb);
    int lat;
    lat = 0;
    @(negedge ap_clk);
    a_vec = a; b_vec = b; acc_clr = clr; ap_start = 1'b1;
    @(posedge ap_clk);
    #1 ap_start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge ap_clk);
      if (c == 1) check({tag, "_idle_in_mac"}, 64'(d_idle), 64'd0);
      if (disturb && c < 4) begin
        a_vec = {$urandom, $urandom};
        b_vec = {$urandom, $urandom};
        acc_clr = ~acc_clr;
        ap_start = c[0];
      end else if (disturb && c == 4) begin
        ap_start = 1'b0;
      end
      if (d_done) begin
        lat = c;
        break;
      end
    end
    check({tag, "_latency"}, 64'(lat), 64'd5);
    check({tag, "_out1"}, 64'(d_out1), 64'(exp));
    check({tag, "_ap_return"}, 64'(d_ret), 64'(exp));
    check({tag, "_vld_ready"}, {62'd0, d_vld, d_ready}, 64'd3);
    check({tag, "_ovf"}, 64'(d_ovf), 64'(exp_ovf));
    @(negedge ap_clk);
    check({tag, "_done_one_cycle"}, {61'd0, d_done, d_vld, d_ready}, 64'd0);
  endtask

  logic [63:0] v1a, v1b, v2a, v2b, va_neg, vb_neg, v_min;
  logic [39:0] b2b_exp [3];
  int n_done, last_c, extra;

  initial begin
    v1a    = pack4(1, 2, 3, 4);
    v1b    = pack4(5, 6, 7, 8);
    v2a    = pack4(-1, 2, -3, 4);
    v2b    = pack4(10, 20, 30, 40);
    va_neg = pack4(-3, 0, 0, 0);
    vb_neg = pack4(7, 0, 0, 0);
    v_min  = pack4(-32768, -32768, -32768, -32768);
    b2b_exp[0] = 40'd70;
    b2b_exp[1] = 40'd100;
    b2b_exp[2] = 40'd70;

    // Reset state, including ap_idle following ap_start.
    #1 ap_rst_n = 1'b0;
    #2;
    check("rst_outputs", {52'd0, d_done, d_ready, d_vld, d_ovf, d_idle, 7'd0}, 64'h10 << 3);
    check("rst_out1", 64'(d_out1), 64'd0);
    check("rst_ap_return", 64'(d_ret), 64'd0);
    ap_start = 1'b1;
    #1 check("rst_idle_follows_start", 64'(d_idle), 64'd0);
    ap_start = 1'b0;
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;

    // Basic dot product and accumulate mode.
    run_txn("basic", v1a, v1b, 1'b1, 40'd70, 1'b0, 1'b0);
    run_txn("accum", v1a, v1b, 1'b0, 40'd140, 1'b0, 1'b0);
    run_txn("neg", va_neg, vb_neg, 1'b1, 40'hFFFFFFFFEB, 1'b0, 1'b0);

    // Overflow on the 32-bit cores; the 40-bit core holds 2^32 exactly.
    run_txn("ovf40", v_min, v_min, 1'b1, 40'h0100000000, 1'b0, 1'b0);
    check("wrap_out1", 64'(w_out1), 64'h0);
    check("wrap_ovf", 64'(w_ovf), 64'd1);
    check("sat_out1", 64'(s_out1), 64'h7FFFFFFF);
    check("sat_ret", 64'(s_ret), 64'h7FFFFFFF);
    check("sat_ovf", 64'(s_ovf), 64'd1);
    run_txn("clean", v1a, v1b, 1'b1, 40'd70, 1'b0, 1'b0);
    check("wrap_clean_out1", 64'(w_out1), 64'd70);
    check("wrap_clean_ovf", 64'(w_ovf), 64'd0);
    check("sat_clean_out1", 64'(s_out1), 64'd70);
    check("sat_clean_ovf", 64'(s_ovf), 64'd0);

    // Asynchronous reset in the second MAC cycle.
    @(negedge ap_clk);
    a_vec = v1a; b_vec = v1b; acc_clr = 1'b1; ap_start = 1'b1;
    @(posedge ap_clk);
    #1 ap_start = 1'b0;
    @(posedge ap_clk);
    #2 check("midrst_partial_acc", 64'(d_out1), 64'd5);
    ap_rst_n = 1'b0;
    #1;
    check("midrst_out1", 64'(d_out1), 64'd0);
    check("midrst_ret", 64'(d_ret), 64'd0);
    check("midrst_flags", {60'd0, d_done, d_ready, d_vld, d_ovf}, 64'd0);
    check("midrst_idle", 64'(d_idle), 64'd1);
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    extra = 0;
    repeat (4) begin
      @(negedge ap_clk);
      if (d_done || !d_idle) extra++;
    end
    check("midrst_no_resume", 64'(extra), 64'd0);
    run_txn("after_rst", v1a, v1b, 1'b1, 40'd70, 1'b0, 1'b0);

    // Back-to-back with ap_start held high and alternating vectors.
    @(negedge ap_clk);
    a_vec = v1a; b_vec = v1b; acc_clr = 1'b1; ap_start = 1'b1;
    n_done = 0;
    last_c = 0;
    for (int c = 1; c <= 40 && n_done < 3; c++) begin
      @(negedge ap_clk);
      if (d_done) begin
        check($sformatf("b2b%0d_out1", n_done), 64'(d_out1), 64'(b2b_exp[n_done]));
        if (n_done == 0) check("b2b_first_latency", 64'(c), 64'd5);
        else             check($sformatf("b2b%0d_interval", n_done), 64'(c - last_c), 64'd6);
        last_c = c;
        n_done++;
        if (n_done == 3) ap_start = 1'b0;
        else if (n_done == 1) begin a_vec = v2a; b_vec = v2b; end
        else begin a_vec = v1a; b_vec = v1b; end
      end
    end
    check("b2b_count", 64'(n_done), 64'd3);
    ap_start = 1'b0;

    // Inputs disturbed during MAC must not affect the result or start another transaction.
    run_txn("ignored", v1a, v1b, 1'b1, 40'd70, 1'b0, 1'b1);
    extra = 0;
    repeat (4) begin
      @(negedge ap_clk);
      if (d_done) extra++;
    end
    check("ignored_extra_done", 64'(extra), 64'd0);
    check("ignored_idle", 64'(d_idle), 64'd1);
    check("ignored_hold", 64'(d_out1), 64'd70);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hls_macc_vec.md
# hls_macc_vec

Parametrised successor to the fixed five-state multiply-accumulate core. It computes a signed dot product of two packed `LANES`-element vectors. The result is optionally accumulated onto the previous result and optionally saturated. Control uses the same `ap_ctrl_hs` block-level handshake (`ap_start`/`ap_done`/`ap_idle`/`ap_ready`) plus an output-valid strobe. It sits beside the existing HLS datapath cores and is driven by the same top-level controller.

## Interface
- `W`, 16: element width, signed two's complement.
- `LANES`, 4: elements per vector, ≥1.
- `ACC_W`, 40: accumulator and result width, ≥2·`W`.
- `SAT`, 0: 0 = wrap modulo 2^`ACC_W`; 1 = saturate each addition.

Ports:
- `ap_clk` input 1: clock; all state updates on its rising edge.
- `ap_rst_n` input 1: asynchronous, active-low reset.
- `ap_start` input 1: request; sampled only in IDLE.
- `ap_done` output 1: one-cycle pulse in DONE.
- `ap_idle` output 1: high in IDLE while `ap_start`=0.
- `ap_ready` output 1: equal to `ap_done`.
- `acc_clr` input 1: sampled with `ap_start`. 1 = start from 0; 0 = start from the previous result.
- `a_vec` input `LANES`·`W`: element i at bits [i·W+W-1 : i·W].
- `b_vec` input `LANES`·`W`: same packing as `a_vec`.
- `out1` output `ACC_W`: result register.
- `out1_ap_vld` output 1: equal to `ap_done`.
- `ovf` output 1: overflow occurred in the current/last transaction.
- `ap_return` output `ACC_W`: equal to `out1`.

## Operation
- States: IDLE, MAC, DONE. Use a one-hot state register and an index counter of width ceil(log2(`LANES`)), minimum 1 bit.
- IDLE with `ap_start`=1:
  - capture `a_vec` and `b_vec` into internal registers;
  - load acc with 0 if `acc_clr`=1, otherwise keep it;
  - clear `ovf`; set idx=0; go to MAC.
- IDLE with `ap_start`=0: stay in IDLE; no register changes.
- MAC, each cycle:
  - p = signed(a[idx]) × signed(b[idx]), 2·`W` bits, sign-extended to `ACC_W`;
  - acc ← acc + p;
  - idx ← idx+1;
  - when idx = `LANES`−1, go to DONE.
- Arithmetic and `ovf`:
  - Signed overflow on any addition sets `ovf` (sticky until the next accepted start).
  - `SAT`=0: keep the wrapped sum.
  - `SAT`=1: clamp to 2^(ACC_W−1)−1 or −2^(ACC_W−1) according to the sign of the true sum; subsequent additions continue from the clamped value.
- DONE: assert `ap_done`, `ap_ready` and `out1_ap_vld` for exactly one cycle, then go to IDLE unconditionally.
- `ap_start` and `acc_clr` are ignored outside IDLE. Input vectors are ignored after capture and may change freely.
- `out1`/`ap_return` show the acc register at all times. The value is final and stable from DONE until the next accepted start plus one cycle.

## Timing
- Reset (`ap_rst_n`=0, effective immediately, including mid-MAC):
  - state = IDLE, acc = 0, idx = 0, `ovf` = 0;
  - `ap_done` = `ap_ready` = `out1_ap_vld` = 0;
  - `out1` = `ap_return` = 0;
  - `ap_idle` = ~`ap_start`.
- Reset release takes effect on the first rising edge with `ap_rst_n`=1. No partial transaction resumes.
- Start accepted at edge k:
  - MAC occupies cycles k+1 … k+`LANES`;
  - DONE occupies cycle k+`LANES`+1;
  - latency is `LANES`+1 cycles from acceptance to `ap_done`.
- If `ap_start` is held high, the next acceptance is at the edge leaving the IDLE cycle after DONE, giving an initiation interval of `LANES`+2 cycles.
- `LANES`=1: MAC lasts one cycle, then DONE.
- `ap_idle` is combinational and low in MAC and DONE.

## Test plan
- Basic dot product (`LANES`=4, `W`=16, `ACC_W`=40, `SAT`=0):
  - stimulus: a={1,2,3,4}, b={5,6,7,8}, `acc_clr`=1, `ap_start` pulsed at edge k;
  - required: `ap_done` and `out1_ap_vld` high only in cycle k+5, `out1`=`ap_return`=70, `ovf`=0.
- Accumulate mode: repeat the same vectors with `acc_clr`=0 → 140. Then a={−3,0,0,0}, b={7,0,0,0} with `acc_clr`=1 → −21, shown as 0xFFFFFFFFEB in 40 bits.
- Overflow, `W`=16, `ACC_W`=32, all elements −32768 in both vectors, `acc_clr`=1:
  - `SAT`=0: `out1`=0x00000000, `ovf`=1;
  - `SAT`=1: `out1`=0x7FFFFFFF, `ovf`=1;
  - next clean transaction clears `ovf`.
- Reset mid-operation: drop `ap_rst_n` during the second MAC cycle. All outputs go to 0 without waiting for a clock edge and `ap_idle` goes high (with `ap_start`=0). After release, a fresh basic transaction returns 70.
- Back-to-back: hold `ap_start`=1 for 3 transactions with alternating vectors. `ap_done` pulses every 6 cycles, and each result is correct.
- Ignored inputs: change `a_vec`/`b_vec`/`acc_clr` and toggle `ap_start` during MAC. The result is unchanged and no extra transaction starts.
